mem_rd_checker: RTL and testbench
=================================

MEM_RD_CHECKER -- requirements
Module: mem_rd_checker

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 8, payload width; the stored memory word is DATA_W+1 bits wide.
REQ-003 Parameter CNT_W, default 8, error counter width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  read request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_addr  in  ADDR_W  address to read.
REQ-010 resp_valid  out  1  response data valid.
REQ-011 resp_ready  in  1  consumer accepts the response.
REQ-012 resp_data  out  DATA_W  payload, which is the stored word without its parity bit.
REQ-013 resp_perr  out  1  parity error on this response.
REQ-014 mem_read  out  1  read strobe to the parity memory.
REQ-015 mem_write  out  1  tied 0 (read-only initiator).
REQ-016 mem_addr  out  ADDR_W  address to the parity memory.
REQ-017 mem_rdata  in  DATA_W+1  memory word {parity, data}; the memory registers it on the edge that samples mem_read.
REQ-018 err_count  out  CNT_W  saturating count of parity errors.
REQ-019 err_addr  out  ADDR_W  address of the most recent parity error.
REQ-020 err_clr  in  1  synchronous clear of err_count and err_addr.

Function
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-022 In IDLE, req_ready=1; on req_valid&&req_ready the block SHALL latch req_addr and go to ISSUE.
REQ-023 In ISSUE, mem_read=1 and mem_addr=the latched address for exactly one cycle, then the FSM SHALL go to WAIT; in all other states mem_read=0.
REQ-024 In WAIT, the block SHALL capture mem_rdata into the response registers and go to RESP.
REQ-025 In RESP, resp_valid=1 with stable resp_data/resp_perr until resp_ready; on resp_valid&&resp_ready the FSM SHALL go to IDLE.
REQ-026 Latency: for a handshake in cycle C0, resp_valid SHALL first be high in cycle C3; the minimum request-to-request spacing is 4 cycles.
REQ-027 req_ready SHALL be 0 in ISSUE, WAIT and RESP; no request is accepted in the cycle the response handshakes.
REQ-028 Parity is even: resp_perr = XOR of all DATA_W+1 bits of the captured word; resp_data = captured[DATA_W-1:0].
REQ-029 On capture with a parity error, err_count SHALL increment by 1 (saturating at 2^CNT_W-1) and err_addr SHALL load the latched address.
REQ-030 If err_clr coincides with an error capture, err_count SHALL become 1 and err_addr SHALL load the new address (the error wins over the clear).
REQ-031 err_clr alone SHALL set err_count=0 and err_addr=0, independent of FSM state.
REQ-032 A held resp_ready=0 SHALL stall the FSM in RESP indefinitely with no memory traffic.

Reset
REQ-033 On rst: FSM=IDLE; req_ready=0 during the reset cycle, then 1; resp_valid=0, resp_data=0, resp_perr=0, mem_read=0, mem_write=0, mem_addr=0, err_count=0, err_addr=0.
REQ-034 rst in any state SHALL abort the in-flight read with no response and no counter update; rst overrides err_clr.

Structure
REQ-035 A shared package mem_chk_pkg SHALL hold the FSM state enum (IDLE, ISSUE, WAIT, RESP) and the default width constants.
REQ-036 One sub-module, sat_counter (parameterised width, inc/clr inputs, saturating), SHALL implement err_count.

Verification
REQ-037 Memory word 9'h0A5 at 16'h0010; request 16'h0010 -> resp_valid in cycle C3, resp_data=8'hA5, resp_perr=0, err_count unchanged.
REQ-038 Corrupted word 9'h1A5 at 16'h1234 -> resp_perr=1, err_count 0->1, err_addr=16'h1234.
REQ-039 256 consecutive corrupted reads with CNT_W=8 -> err_count stops at 8'hFF.
REQ-040 resp_ready held 0 for 10 cycles -> resp_valid/resp_data stable, mem_read=0, req_ready=0 throughout.
REQ-041 err_clr asserted in the WAIT cycle of an erroneous read -> err_count=1, err_addr=the new address.
REQ-042 rst asserted in WAIT -> next cycle in IDLE, no resp_valid pulse, err_count=0.

Source files
------------

// File: rtl/mem_chk_pkg.sv
// Shared types and default widths for the parity read checker.
// FSM state encoding plus width constants used by all files.
package mem_chk_pkg;

  localparam int ADDR_W_D = 16;
  localparam int DATA_W_D = 8;
  localparam int CNT_W_D  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/mem_rd_checker_if.sv
// Request/response and parity-memory bus for mem_rd_checker.
// slave: checker side; master: requester plus memory side.
interface mem_rd_checker_if
  import mem_chk_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_perr;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W:0]   mem_rdata;

  modport slave (
    input  req_valid,
    input  req_addr,
    input  resp_ready,
    input  mem_rdata,
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_perr,
    output mem_read,
    output mem_write,
    output mem_addr
  );

  modport master (
    output req_valid,
    output req_addr,
    output resp_ready,
    output mem_rdata,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_perr,
    input  mem_read,
    input  mem_write,
    input  mem_addr
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst, inc, clr, cnt. inc beats clr (result 1).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      if (clr) begin
        cnt <= ONE;
      end else if (cnt != MAX) begin
        cnt <= cnt + ONE;
      end
    end else if (clr) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_rd_checker.sv
// Parity-checked single-outstanding memory read engine.
// Ports: clk, rst, bus (slave), err_clr, err_count, err_addr.
module mem_rd_checker
  import mem_chk_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic              clk,
  input  logic              rst,
  mem_rd_checker_if.slave   bus,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_addr
);

  state_e            state;
  logic              rdy_q;
  logic              rd_q;
  logic              vld_q;
  logic              perr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              perr_w;
  logic              err_inc;

  assign perr_w  = ^bus.mem_rdata;
  assign err_inc = (state == WAIT) & perr_w;

  // rdy_q is already 1 in reset so the
  // block is ready the cycle rst drops.
  assign bus.req_ready  = rdy_q & ~rst;
  assign bus.mem_read   = rd_q;
  assign bus.mem_write  = 1'b0;
  assign bus.mem_addr   = addr_q;
  assign bus.resp_valid = vld_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_perr  = perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rdy_q  <= 1'b1;
      rd_q   <= 1'b0;
      vld_q  <= 1'b0;
      perr_q <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            rd_q   <= 1'b1;
            rdy_q  <= 1'b0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          rd_q  <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          data_q <= bus.mem_rdata[DATA_W-1:0];
          perr_q <= perr_w;
          vld_q  <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr <= '0;
    end else if (err_inc) begin
      err_addr <= addr_q;
    end else if (err_clr) begin
      err_addr <= '0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (err_clr),
    .cnt (err_count)
  );

endmodule

// File: tb/tb_mem_rd_checker.sv
// Directed bench for mem_rd_checker with a cycle model.
// Drives requests, models the parity memory, checks outputs.
module tb_mem_rd_checker;

  localparam int CMAX = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic [7:0]  err_count;
  logic [15:0] err_addr;

  mem_rd_checker_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_rd_checker #(
    .ADDR_W (16),
    .DATA_W (8),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  logic [8:0] mem [logic [15:0]];

  always @(posedge clk)
    if (bus.mem_read)
      bus.mem_rdata <= mem[bus.mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string n,
                     logic [31:0] a,
                     logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               n, a, e);
    end
  endtask

  // Transaction-level model: one read in
  // flight, phase = cycles since acceptance.
  bit          armed = 0;
  bit          inf = 0;
  int          cyc = 0;
  int          acc = 0;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  bit          m_perr;
  int          m_cnt;
  logic [15:0] m_eaddr;

  always @(posedge clk) begin
    int k;
    bit err;
    logic [8:0] w;
    k = cyc - acc;
    err = 0;
    if (rst) begin
      inf = 0;
      m_cnt = 0;
      m_eaddr = '0;
      armed = 1;
    end else begin
      if (inf && k == 2) begin
        w = mem[m_addr];
        m_data = w[7:0];
        m_perr = ^w;
        err = m_perr;
      end
      if (err) begin
        if (err_clr) m_cnt = 1;
        else if (m_cnt < CMAX) m_cnt++;
        m_eaddr = m_addr;
      end else if (err_clr) begin
        m_cnt = 0;
        m_eaddr = '0;
      end
      if (inf && k >= 3 && bus.resp_ready)
        inf = 0;
      else if (!inf && bus.req_valid) begin
        inf = 1;
        acc = cyc;
        m_addr = bus.req_addr;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    int k;
    bit e_rd;
    bit e_vld;
    if (armed) begin
      k = cyc - acc;
      e_rd  = inf && k == 1;
      e_vld = inf && k >= 3;
      chk("req_ready", {31'd0, bus.req_ready},
          {31'd0, !rst && !inf});
      chk("mem_read", {31'd0, bus.mem_read},
          {31'd0, e_rd});
      chk("mem_write", {31'd0, bus.mem_write},
          32'd0);
      chk("resp_valid", {31'd0, bus.resp_valid},
          {31'd0, e_vld});
      chk("err_count", {24'd0, err_count},
          m_cnt);
      chk("err_addr", {16'd0, err_addr},
          {16'd0, m_eaddr});
      if (e_rd)
        chk("mem_addr", {16'd0, bus.mem_addr},
            {16'd0, m_addr});
      if (e_vld) begin
        chk("resp_data", {24'd0, bus.resp_data},
            {24'd0, m_data});
        chk("resp_perr", {31'd0, bus.resp_perr},
            {31'd0, m_perr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle C3 of the read.
  task automatic rd(logic [15:0] a,
                    logic [8:0] w,
                    bit clr_w,
                    bit rst_w);
    mem[a] = w;
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    tick();
    bus.req_valid = 1'b0;
    tick();
    err_clr = clr_w;
    rst = rst_w;
    tick();
    err_clr = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    err_clr = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.resp_ready = 1'b1;
    tick();
    tick();
    chk("rst_ready", {31'd0, bus.req_ready}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready",
        {31'd0, bus.req_ready}, 1);
    chk("post_rst_vld",
        {31'd0, bus.resp_valid}, 0);
    chk("post_rst_data",
        {24'd0, bus.resp_data}, 0);
    chk("post_rst_maddr",
        {16'd0, bus.mem_addr}, 0);
    chk("post_rst_cnt", {24'd0, err_count}, 0);
    chk("post_rst_eaddr", {16'd0, err_addr}, 0);
    tick();

    rd(16'h0010, 9'h0A5, 0, 0);
    chk("c3_vld", {31'd0, bus.resp_valid}, 1);
    chk("c3_data", {24'd0, bus.resp_data}, 'hA5);
    chk("c3_perr", {31'd0, bus.resp_perr}, 0);
    chk("c3_cnt", {24'd0, err_count}, 0);
    tick();

    rd(16'h1234, 9'h1A5, 0, 0);
    chk("bad_perr", {31'd0, bus.resp_perr}, 1);
    chk("bad_cnt", {24'd0, err_count}, 1);
    chk("bad_eaddr", {16'd0, err_addr}, 'h1234);
    tick();

    rd(16'h00FF, 9'h0FF, 0, 0);
    tick();
    rd(16'h5555, 9'h1FF, 0, 0);
    tick();
    rd(16'hFFFF, 9'h000, 0, 0);
    tick();
    rd(16'h8001, 9'h100, 0, 0);
    chk("pat_cnt", {24'd0, err_count}, 3);
    chk("pat_eaddr", {16'd0, err_addr}, 'h8001);
    tick();

    bus.resp_ready = 1'b0;
    rd(16'h0042, 9'h03C, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_vld",
          {31'd0, bus.resp_valid}, 1);
      chk("stall_data",
          {24'd0, bus.resp_data}, 'h3C);
      chk("stall_rd", {31'd0, bus.mem_read}, 0);
      chk("stall_rdy",
          {31'd0, bus.req_ready}, 0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();

    rd(16'hBEEF, 9'h1A5, 1, 0);
    chk("clrw_cnt", {24'd0, err_count}, 1);
    chk("clrw_eaddr", {16'd0, err_addr}, 'hBEEF);
    tick();

    rd(16'h0ABC, 9'h1A5, 0, 1);
    chk("rstw_vld", {31'd0, bus.resp_valid}, 0);
    chk("rstw_rdy", {31'd0, bus.req_ready}, 1);
    chk("rstw_cnt", {24'd0, err_count}, 0);
    tick();
    chk("rstw_vld2", {31'd0, bus.resp_valid}, 0);

    rd(16'h0777, 9'h1A5, 0, 0);
    chk("pre_clr_cnt", {24'd0, err_count}, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_cnt", {24'd0, err_count}, 0);
    chk("clr_eaddr", {16'd0, err_addr}, 0);
    tick();

    for (int i = 0; i < 256; i++) begin
      rd(16'h2000 + 16'(i), 9'h1A5, 0, 0);
      tick();
    end
    chk("sat_cnt", {24'd0, err_count}, 'hFF);
    chk("sat_eaddr", {16'd0, err_addr}, 'h20FF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
